imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
// Write-side counterpart of the processor's instruction fetch. Takes a program
// over a valid/ready word stream and writes it into instruction memory
// sequentially from address 0. It holds the processor in reset until the load
// completes and its checksum verifies. It sits between the host/test interface
// and the instruction memory write port.
// PARAMETERS
// ADDR_W  4   instruction memory address width
// DATA_W  4   instruction word width; also the stream word width
// DEPTH   16  memory words (must equal 2**ADDR_W)
// PORTS
// clk        in   1       system clock; all state changes on rising edge
// reset      in   1       asynchronous, active-low reset
// start      in   1       one-cycle request to begin a load; sampled in IDLE/DONE/ERR
// in_valid   in   1       stream word valid
// in_data    in   DATA_W  stream word
// in_ready   out  1       loader accepts a word this cycle
// mem_we     out  1       instruction memory write enable, one cycle per word
// mem_addr   out  ADDR_W  write address
// mem_wdata  out  DATA_W  write data
// cpu_hold   out  1       1 = keep processor/PC in reset
// done       out  1       program loaded and checksum matched
// error      out  1       checksum mismatch on the last load
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, in_ready=0, mem_we=0, mem_addr=0,
//   mem_wdata=0, cpu_hold=1, done=0, error=0, idx=0, csum=0.
// - Handshake: a word transfers on a rising edge where in_valid & in_ready=1.
//   in_valid may gap for any number of cycles. in_data is ignored when no
//   transfer occurs. in_ready is a registered function of the state.
// - Stream format: LEN word, then N data words, then one CHK word.
//   N = LEN, except LEN=0 means N=DEPTH. CHK = XOR of all N data words
//   (LEN is excluded from the XOR).
// - States:
//   IDLE:    in_ready=0. start -> GET_LEN, cpu_hold=1, done=0, error=0.
//   GET_LEN: in_ready=1. On transfer, latch N, idx=0, csum=0 -> LOAD.
//   LOAD:    in_ready=1. On each transfer: csum^=in_data, idx++.
//            Registered write: mem_we=1, mem_addr=idx (pre-increment),
//            mem_wdata=in_data, all during the cycle after the transfer.
//            After the Nth word -> CHECK. Back-to-back transfers give
//            back-to-back writes.
//   CHECK:   in_ready=1. On transfer, if in_data==csum -> DONE, else -> ERR.
//   DONE:    in_ready=0, done=1, cpu_hold=0. start -> GET_LEN.
//   ERR:     in_ready=0, error=1, cpu_hold=1. start -> GET_LEN.
// - start is ignored in GET_LEN/LOAD/CHECK; no restart mid-load.
// - mem_we is 0 in every cycle not immediately following a LOAD transfer.
//   mem_addr/mem_wdata hold their last values when mem_we=0.
// - idx width is ADDR_W+1. The last write address is N-1; no wrap occurs.
//   A full DEPTH load writes addresses 0..DEPTH-1.
// - The CHK word is never written to memory.
// - Reset mid-load aborts immediately to reset values. Memory contents already
//   written are left as-is, and cpu_hold=1 guarantees the processor never runs
//   a partial program.
// - Latency: done rises on the edge after the CHK transfer. From start to done
//   takes at least N+3 cycles with in_valid held high.
// TESTING
// - start; stream 3,A,5,F,0 with in_valid=1 -> writes (0,A),(1,5),(2,F) on
//   consecutive cycles; done=1, cpu_hold=0, error=0.
// - LEN=0, data 0..F, CHK=0 -> 16 writes to addresses 0..F; mem_addr never
//   wraps; done=1.
// - start; stream 2,3,6,4 (CHK should be 5) -> two writes, then error=1,
//   cpu_hold=1, done=0; a new start with a good stream -> done=1, error=0.
// - Same as the first test with in_valid low for 0-3 random cycles between
//   words -> identical writes; in_data changes while in_valid=0 have no effect.
// - Assert reset low after the 2nd data word of a 4-word load -> all outputs
//   return to reset values immediately; no further writes; IDLE.
// - Pulse start during LOAD -> ignored: the load completes normally, and no
//   return to GET_LEN occurs.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams a program (LEN, N data words, CHK) into instruction
//               memory from address 0. Holds the processor in reset until the
//               load completes and the XOR checksum of the data words matches.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // One extra bit so a full DEPTH-word count is representable without wrap.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_N = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_LEN = 3'd1,
    S_LOAD    = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_next;
  logic [CNT_W-1:0]  len_n;
  logic [CNT_W-1:0]  len_n_next;
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] csum_next;
  logic              wr_next;
  logic              xfer;
  logic [CNT_W-1:0]  len_word;

  assign xfer = in_valid & in_ready;

  // The LEN word is resized to the counter width before use.
  generate
    if (DATA_W >= CNT_W) begin : g_len_trunc
      assign len_word = in_data[CNT_W-1:0];
    end else begin : g_len_ext
      assign len_word = {{(CNT_W-DATA_W){1'b0}}, in_data};
    end
  endgenerate

  // Next-state, counter, checksum and write-request logic.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    len_n_next = len_n;
    csum_next  = csum;
    wr_next    = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_GET_LEN;
      end
      S_GET_LEN: begin
        if (xfer) begin
          // LEN=0 encodes a full-memory load.
          len_n_next = (len_word == '0) ? FULL_N : len_word;
          idx_next   = '0;
          csum_next  = '0;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          csum_next = csum ^ in_data;
          idx_next  = idx + 1'b1;
          wr_next   = 1'b1;
          if (idx_next == len_n) state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) state_next = (in_data == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Load counters, checksum accumulator and the registered memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      len_n     <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      idx    <= idx_next;
      len_n  <= len_n_next;
      csum   <= csum_next;
      mem_we <= wr_next;
      if (wr_next) begin
        // Address is the pre-increment index; no wrap since idx < N <= DEPTH.
        mem_addr  <= idx[ADDR_W-1:0];
        mem_wdata <= in_data;
      end
    end
  end

  // Status outputs registered from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      in_ready <= (state_next == S_GET_LEN) || (state_next == S_LOAD) ||
                  (state_next == S_CHECK);
      cpu_hold <= (state_next != S_DONE);
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERR);
    end
  end

endmodule
`default_nettype wire
